// File: rtl/alu_pkg.sv
// Shared opcode constants, default datapath width and issue-FSM state type.
package alu_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_NOR = 3'b100;
  localparam logic [2:0] OP_RSV = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } alu_state_e;

  // SUB and SLT both run the adder as a + ~b + 1.
  function automatic logic op_inverts_b(input logic [2:0] op);
    return (op == OP_SUB) || (op == OP_SLT);
  endfunction

endpackage

// File: rtl/alu_req_fifo.sv
// Two-entry in-order request FIFO; the caller never pushes when full or pops when empty.
module alu_req_fifo #(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          empty,
  output logic          full
);

  logic [DW-1:0] mem_q [2];
  logic          wptr_q;
  logic          rptr_q;
  logic [1:0]    count_q;

  assign rdata = mem_q[rptr_q];
  assign empty = (count_q == 2'd0);
  assign full  = (count_q == 2'd2);

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wptr_q] <= wdata;
        wptr_q        <= ~wptr_q;
      end
      if (pop) begin
        rptr_q <= ~rptr_q;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues buffered requests to an external ALU of fixed latency and holds each
// result on a valid/ready response port; also accumulates an ADD/SUB overflow flag.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = DEFAULT_WIDTH,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [2:0]       alu_operation,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_b_invert,
  output logic             alu_carry_in,
  input  logic [WIDTH-1:0] alu_c,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  input  logic             alu_carry_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [2:0]       rsp_op,
  output logic [WIDTH-1:0] rsp_c,
  output logic             rsp_zero,
  output logic             rsp_overflow,
  output logic             rsp_carry_out,
  output logic             ovf_sticky,
  input  logic             ovf_clr
);

  localparam int unsigned DW = 3 + 2 * WIDTH;
  localparam int unsigned CW = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;

  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_empty;
  logic          fifo_full;
  logic [DW-1:0] fifo_wdata;
  logic [DW-1:0] fifo_rdata;

  logic [2:0]       head_op;
  logic [WIDTH-1:0] head_a;
  logic [WIDTH-1:0] head_b;

  alu_state_e       state_q;
  logic [CW-1:0]    cnt_q;
  logic [2:0]       alu_op_q;
  logic [WIDTH-1:0] alu_a_q;
  logic [WIDTH-1:0] alu_b_q;
  logic             alu_inv_q;
  logic             alu_cin_q;
  logic             rsp_valid_q;
  logic [2:0]       rsp_op_q;
  logic [WIDTH-1:0] rsp_c_q;
  logic             rsp_zero_q;
  logic             rsp_ovf_q;
  logic             rsp_cout_q;
  logic             ovf_sticky_q;
  logic             capture;

  alu_req_fifo #(
    .DW (DW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign req_ready  = !rst && !fifo_full;
  assign fifo_push  = req_valid && req_ready;
  assign fifo_wdata = {req_op, req_a, req_b};
  assign {head_op, head_a, head_b} = fifo_rdata;

  // Pops happen only when the FSM is about to issue: from IDLE, or on a HOLD handshake.
  always_comb begin
    fifo_pop = 1'b0;
    if (!rst && !fifo_empty) begin
      fifo_pop = (state_q == ST_IDLE) ||
                 (state_q == ST_HOLD && rsp_valid_q && rsp_ready);
    end
  end

  assign capture = (state_q == ST_WAIT) && (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      alu_op_q     <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_inv_q    <= 1'b0;
      alu_cin_q    <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_op_q     <= '0;
      rsp_c_q      <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_ovf_q    <= 1'b0;
      rsp_cout_q   <= 1'b0;
      ovf_sticky_q <= 1'b0;
    end else begin
      if (capture && alu_overflow && (alu_op_q == OP_ADD || alu_op_q == OP_SUB)) begin
        ovf_sticky_q <= 1'b1;
      end else if (ovf_clr) begin
        ovf_sticky_q <= 1'b0;
      end

      if (fifo_pop) begin
        alu_op_q  <= head_op;
        alu_a_q   <= head_a;
        alu_b_q   <= head_b;
        alu_inv_q <= op_inverts_b(head_op);
        alu_cin_q <= op_inverts_b(head_op);
        cnt_q     <= CW'(ALU_LAT);
      end

      case (state_q)
        ST_IDLE: begin
          if (fifo_pop) begin
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else begin
            rsp_op_q    <= alu_op_q;
            rsp_c_q     <= alu_c;
            rsp_zero_q  <= alu_zero;
            rsp_ovf_q   <= alu_overflow;
            rsp_cout_q  <= alu_carry_out;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (rsp_valid_q && rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= fifo_pop ? ST_WAIT : ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign alu_operation = alu_op_q;
  assign alu_a         = alu_a_q;
  assign alu_b         = alu_b_q;
  assign alu_b_invert  = alu_inv_q;
  assign alu_carry_in  = alu_cin_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_op        = rsp_op_q;
  assign rsp_c         = rsp_c_q;
  assign rsp_zero      = rsp_zero_q;
  assign rsp_overflow  = rsp_ovf_q;
  assign rsp_carry_out = rsp_cout_q;
  assign ovf_sticky    = ovf_sticky_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with a one-cycle registered ALU model attached.
module tb_alu_issue_ctrl;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [2:0]   req_op = '0;
  logic [W-1:0] req_a = '0;
  logic [W-1:0] req_b = '0;
  logic [2:0]   alu_operation;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic         alu_b_invert;
  logic         alu_carry_in;
  logic [W-1:0] alu_c = '0;
  logic         alu_zero = 1'b0;
  logic         alu_overflow = 1'b0;
  logic         alu_carry_out = 1'b0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [2:0]   rsp_op;
  logic [W-1:0] rsp_c;
  logic         rsp_zero;
  logic         rsp_overflow;
  logic         rsp_carry_out;
  logic         ovf_sticky;
  logic         ovf_clr = 1'b0;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] c;
    logic         z;
    logic         v;
    logic         co;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  alu_issue_ctrl #(
    .WIDTH   (W),
    .ALU_LAT (1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op        (req_op),
    .req_a         (req_a),
    .req_b         (req_b),
    .alu_operation (alu_operation),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_b_invert  (alu_b_invert),
    .alu_carry_in  (alu_carry_in),
    .alu_c         (alu_c),
    .alu_zero      (alu_zero),
    .alu_overflow  (alu_overflow),
    .alu_carry_out (alu_carry_out),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_op        (rsp_op),
    .rsp_c         (rsp_c),
    .rsp_zero      (rsp_zero),
    .rsp_overflow  (rsp_overflow),
    .rsp_carry_out (rsp_carry_out),
    .ovf_sticky    (ovf_sticky),
    .ovf_clr       (ovf_clr)
  );

  // ALU model: one adder driven by the invert/carry-in controls, one output register stage.
  logic [W-1:0] bb;
  logic [W:0]   sum;
  logic         add_ovf;
  logic         arith;
  logic [W-1:0] res;

  always_comb begin
    bb      = alu_b_invert ? ~alu_b : alu_b;
    sum     = {1'b0, alu_a} + {1'b0, bb} + {{W{1'b0}}, alu_carry_in};
    add_ovf = (alu_a[W-1] == bb[W-1]) && (sum[W-1] != alu_a[W-1]);
    arith   = (alu_operation == 3'b010) || (alu_operation == 3'b110) || (alu_operation == 3'b111);
    res     = '0;
    case (alu_operation)
      3'b000: res = alu_a & alu_b;
      3'b001: res = alu_a | alu_b;
      3'b010: res = sum[W-1:0];
      3'b011: res = alu_a ^ alu_b;
      3'b100: res = ~(alu_a | alu_b);
      3'b110: res = sum[W-1:0];
      3'b111: res = {{(W-1){1'b0}}, add_ovf ^ sum[W-1]};
      default: res = '0;
    endcase
  end

  always @(posedge clk) begin
    alu_c         <= res;
    alu_zero      <= (res == '0);
    alu_overflow  <= arith && add_ovf;
    alu_carry_out <= arith && sum[W];
  end

  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic [W:0] s;
    logic [W-1:0] d;
    e.op = op;
    e.c  = '0;
    e.v  = 1'b0;
    e.co = 1'b0;
    d    = a - b;
    case (op)
      3'b000: e.c = a & b;
      3'b001: e.c = a | b;
      3'b010: begin
        s    = {1'b0, a} + {1'b0, b};
        e.c  = s[W-1:0];
        e.co = s[W];
        e.v  = (a[W-1] == b[W-1]) && (e.c[W-1] != a[W-1]);
      end
      3'b011: e.c = a ^ b;
      3'b100: e.c = ~(a | b);
      3'b110: begin
        e.c  = d;
        e.co = (a >= b);
        e.v  = (a[W-1] != b[W-1]) && (d[W-1] != a[W-1]);
      end
      3'b111: begin
        e.c  = ($signed(a) < $signed(b)) ? 1 : 0;
        e.co = (a >= b);
        e.v  = (a[W-1] != b[W-1]) && (d[W-1] != a[W-1]);
      end
      default: e.c = '0;
    endcase
    e.z = (e.c == '0);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (req_ready) begin
        sb.push_back(model(op, a, b));
        tick();
        req_valid = 1'b0;
        return;
      end
      tick();
    end
    checks++;
    failures++;
    $display("FAIL send_timeout op=%b req_ready=%b required=1", op, req_ready);
    req_valid = 1'b0;
  endtask

  task automatic collect(output int lat);
    exp_t e;
    lat = -1;
    for (int i = 0; i < 60; i++) begin
      if (rsp_valid) begin
        lat = i;
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL rsp_unexpected got op=%b c=%h", rsp_op, rsp_c);
        end else begin
          e = sb.pop_front();
          if ({rsp_op, rsp_c, rsp_zero, rsp_overflow, rsp_carry_out} !== {e.op, e.c, e.z, e.v, e.co}) begin
            failures++;
            $display("FAIL rsp_payload got op=%b c=%h z=%b v=%b co=%b required op=%b c=%h z=%b v=%b co=%b",
                     rsp_op, rsp_c, rsp_zero, rsp_overflow, rsp_carry_out, e.op, e.c, e.z, e.v, e.co);
          end
        end
        if (rsp_ready) tick();
        return;
      end
      tick();
    end
    checks++;
    failures++;
    $display("FAIL rsp_timeout rsp_valid=%b required=1", rsp_valid);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if ({alu_operation, alu_a, alu_b, alu_b_invert, alu_carry_in, rsp_valid, rsp_op, rsp_c,
         rsp_zero, rsp_overflow, rsp_carry_out, ovf_sticky, req_ready} !== '0) begin
      failures++;
      $display("FAIL reset_outputs rsp_valid=%b req_ready=%b alu_op=%b ovf=%b required all 0",
               rsp_valid, req_ready, alu_operation, ovf_sticky);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready got=%b required=1", req_ready);
    end
    tick();
  endtask

  task automatic test_add_latency();
    int lat;
    rsp_ready = 1'b1;
    send(3'b010, 32'd5, 32'd7);
    collect(lat);
    checks++;
    if (lat !== 3) begin
      failures++;
      $display("FAIL add_latency got=%0d required=3", lat);
    end
  endtask

  task automatic test_sub_flags();
    int lat;
    rsp_ready = 1'b1;
    send(3'b110, 32'd7, 32'd7);
    tick();
    checks++;
    if ({alu_operation, alu_b_invert, alu_carry_in, alu_a, alu_b} !== {3'b110, 2'b11, 32'd7, 32'd7}) begin
      failures++;
      $display("FAIL sub_alu_drive got op=%b inv=%b cin=%b a=%h b=%h required op=110 inv=1 cin=1 a=7 b=7",
               alu_operation, alu_b_invert, alu_carry_in, alu_a, alu_b);
    end
    collect(lat);
  endtask

  task automatic test_ovf_sticky();
    int lat;
    rsp_ready = 1'b1;
    checks++;
    if (ovf_sticky !== 1'b0) begin
      failures++;
      $display("FAIL ovf_initial got=%b required=0", ovf_sticky);
    end
    send(3'b010, 32'h7FFF_FFFF, 32'd1);
    collect(lat);
    checks++;
    if (ovf_sticky !== 1'b1) begin
      failures++;
      $display("FAIL ovf_set got=%b required=1", ovf_sticky);
    end
    send(3'b010, 32'h7FFF_FFFF, 32'd1);
    tick();
    tick();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    checks++;
    if ({ovf_sticky, rsp_valid} !== 2'b11) begin
      failures++;
      $display("FAIL ovf_set_beats_clr got sticky=%b rsp_valid=%b required 1 1", ovf_sticky, rsp_valid);
    end
    collect(lat);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    checks++;
    if (ovf_sticky !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clear got=%b required=0", ovf_sticky);
    end
  endtask

  task automatic test_ops();
    logic [2:0] ops [7];
    logic [W-1:0] a;
    logic [W-1:0] b;
    int lat;
    ops = '{3'b000, 3'b001, 3'b011, 3'b100, 3'b101, 3'b111, 3'b111};
    rsp_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      a = $urandom;
      b = $urandom;
      if (i == 6) begin
        a = 32'h8000_0000;
        b = 32'd1;
      end
      send(ops[i], a, b);
      tick();
      checks++;
      if ({alu_operation, alu_b_invert, alu_carry_in} !==
          {ops[i], ((ops[i] == 3'b110 || ops[i] == 3'b111) ? 2'b11 : 2'b00)}) begin
        failures++;
        $display("FAIL op_drive got op=%b inv=%b cin=%b for op=%b", alu_operation, alu_b_invert,
                 alu_carry_in, ops[i]);
      end
      collect(lat);
    end
    checks++;
    if (ovf_sticky !== 1'b0) begin
      failures++;
      $display("FAIL ovf_slt_ignored got=%b required=0", ovf_sticky);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic seen;
    rsp_ready = 1'b0;
    send(3'b010, 32'd100, 32'd23);
    send(3'b011, 32'hF0F0_1234, 32'h0FF0_4321);
    send(3'b111, 32'hFFFF_FFFE, 32'd3);
    checks++;
    if (req_ready !== 1'b0) begin
      failures++;
      $display("FAIL b2b_full_ready got=%b required=0", req_ready);
    end
    repeat (5) tick();
    checks++;
    if ({req_ready, rsp_valid, rsp_op, rsp_c} !== {1'b0, 1'b1, 3'b010, 32'd123}) begin
      failures++;
      $display("FAIL b2b_hold got ready=%b valid=%b op=%b c=%h required ready=0 valid=1 op=010 c=7b",
               req_ready, rsp_valid, rsp_op, rsp_c);
    end
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) collect(lat);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      seen = seen | rsp_valid;
      tick();
    end
    checks++;
    if ({seen, req_ready} !== 2'b01) begin
      failures++;
      $display("FAIL b2b_drain got extra_rsp=%b ready=%b required extra_rsp=0 ready=1", seen, req_ready);
    end
  endtask

  task automatic test_reset_mid_wait();
    int lat;
    logic seen;
    rsp_ready = 1'b1;
    send(3'b010, 32'd1, 32'd1);
    send(3'b001, 32'd2, 32'd4);
    rst = 1'b1;
    tick();
    checks++;
    if ({req_ready, rsp_valid, alu_operation, alu_a} !== '0) begin
      failures++;
      $display("FAIL midreset_held got ready=%b valid=%b alu_op=%b alu_a=%h required all 0",
               req_ready, rsp_valid, alu_operation, alu_a);
    end
    rst = 1'b0;
    sb.delete();
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL midreset_ready got=%b required=1", req_ready);
    end
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      seen = seen | rsp_valid;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL midreset_no_rsp got rsp_valid_seen=%b required=0", seen);
    end
    send(3'b010, 32'd40, 32'd2);
    collect(lat);
  endtask

  initial begin
    test_reset();
    test_add_latency();
    test_sub_flags();
    test_ovf_sticky();
    test_ops();
    test_back_to_back();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter WIDTH SHALL default to 32 and set the operand and result width.
REQ-003 Parameter ALU_LAT SHALL default to 1 and give the ALU input-to-output register latency in cycles (0 = combinational).
REQ-004 Port clk SHALL be an input, 1 bit, the single clock.
REQ-005 Port rst SHALL be an input, 1 bit, synchronous active-high reset.
REQ-006 Ports req_valid (input, 1) and req_ready (output, 1) SHALL form the request handshake.
REQ-007 Ports req_op (input, 3), req_a (input, WIDTH) and req_b (input, WIDTH) SHALL carry the request payload.
REQ-008 Outputs alu_operation (3), alu_a (WIDTH), alu_b (WIDTH), alu_b_invert (1) and alu_carry_in (1) SHALL drive the ALU.
REQ-009 Inputs alu_c (WIDTH), alu_zero (1), alu_overflow (1) and alu_carry_out (1) SHALL carry the ALU results.
REQ-010 Ports rsp_valid (output, 1) and rsp_ready (input, 1) SHALL form the response handshake.
REQ-011 Outputs rsp_op (3), rsp_c (WIDTH), rsp_zero, rsp_overflow and rsp_carry_out (1 each) SHALL carry the response payload.
REQ-012 Output ovf_sticky (1) and input ovf_clr (1) SHALL provide an accumulated overflow flag and its clear.

Function
REQ-013 Requests SHALL be buffered in a 2-entry in-order FIFO; push on req_valid&&req_ready; req_ready = not full, with no bypass.
REQ-014 A push and a pop on the same edge SHALL leave the count unchanged; a push while full SHALL never occur.
REQ-015 The FSM SHALL have the states IDLE, WAIT and HOLD.
REQ-016 In IDLE with the FIFO non-empty, the block SHALL pop the head, register alu_* from it, load cnt=ALU_LAT and go to WAIT.
REQ-017 In WAIT with cnt!=0, the block SHALL decrement cnt; with cnt==0 it SHALL capture alu_c and the flags together with the op into rsp_*, set rsp_valid and go to HOLD.
REQ-018 Latency: with the request pushed into an empty FIFO at edge E in IDLE, the pop SHALL occur at E+1, the capture at E+2+ALU_LAT, and rsp_valid SHALL be high from then on.
REQ-019 In HOLD, rsp_* SHALL stay stable until rsp_valid&&rsp_ready.
REQ-020 On that handshake edge, if the FIFO is non-empty, the block SHALL pop the next request and go to WAIT with rsp_valid low; otherwise it SHALL go to IDLE.
REQ-021 alu_b_invert and alu_carry_in SHALL both be 1 for SUB (110) and SLT (111), and 0 for every other op.
REQ-022 alu_operation SHALL pass req_op through unchanged; the reserved op 101 SHALL be forwarded without special handling.
REQ-023 alu_* outputs SHALL hold their value outside a pop.
REQ-024 ovf_sticky SHALL set on a capture with alu_overflow=1 and op ADD or SUB, and SHALL clear on ovf_clr; a simultaneous set and clear SHALL leave it set.

Reset
REQ-025 While rst is high, the state SHALL be IDLE, the FIFO empty, cnt=0, all outputs 0 and req_ready 0.
REQ-026 In the first cycle after rst deasserts, req_ready SHALL be 1.
REQ-027 A reset mid-WAIT or mid-HOLD SHALL discard the in-flight and buffered requests and produce no response.

Structure
REQ-028 Shared package alu_pkg SHALL hold the opcode constants (AND 000, OR 001, ADD 010, XOR 011, NOR 100, reserved 101, SUB 110, SLT 111), the default WIDTH and the FSM state type.
REQ-029 The FIFO SHALL be a sub-module named alu_req_fifo (2 entries, parameterised payload width); all other logic SHALL be inline.

Verification
REQ-030 ADD 5+7 pushed at edge E with ALU_LAT=1 and rsp_ready=1 -> capture at E+3 with rsp_c=12, rsp_zero=0 and rsp_overflow=0.
REQ-031 SUB 7-7 -> alu_b_invert=1 and alu_carry_in=1 during WAIT; rsp_c=0 and rsp_zero=1.
REQ-032 ADD 0x7FFFFFFF+1 -> rsp_overflow=1 and ovf_sticky=1; then ovf_clr together with another overflowing ADD capture -> ovf_sticky stays 1; ovf_clr alone -> 0.
REQ-033 rsp_ready=0 with pushes of ops A, B, C back-to-back -> A is held in HOLD, B and C fill the FIFO, req_ready=0 while full; releasing rsp_ready -> responses return in order A, B, C with no loss or duplication.
REQ-034 rst pulsed for one cycle mid-WAIT with one entry buffered -> no rsp_valid afterwards, FIFO empty, req_ready=1 in the first cycle after release.
